// File: rtl/cpu_multisim_client_if.sv
// Handshake bundle between the CPU, the multisim client block and the
// cpu_to_noc / noc_to_cpu channel endpoints.
interface cpu_multisim_client_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  cpu_req_vld;
    logic                  cpu_req_rdy;
    logic [DATA_WIDTH-1:0] cpu_req_data;
    logic                  cpu_rsp_vld;
    logic                  cpu_rsp_rdy;
    logic [DATA_WIDTH-1:0] cpu_rsp_data;
    logic                  cpu_last;
    logic                  chan_tx_vld;
    logic                  chan_tx_rdy;
    logic [DATA_WIDTH-1:0] chan_tx_data;
    logic                  chan_rx_vld;
    logic                  chan_rx_rdy;
    logic [DATA_WIDTH-1:0] chan_rx_data;
    logic [7:0]            outstanding;
    logic                  rsp_err;
    logic                  transactions_done;

    modport slave (
        input  cpu_req_vld, cpu_req_data, cpu_rsp_rdy, cpu_last,
               chan_tx_rdy, chan_rx_vld, chan_rx_data,
        output cpu_req_rdy, cpu_rsp_vld, cpu_rsp_data,
               chan_tx_vld, chan_tx_data, chan_rx_rdy,
               outstanding, rsp_err, transactions_done
    );

    modport master (
        output cpu_req_vld, cpu_req_data, cpu_rsp_rdy, cpu_last,
               chan_tx_rdy, chan_rx_vld, chan_rx_data,
        input  cpu_req_rdy, cpu_rsp_vld, cpu_rsp_data,
               chan_tx_vld, chan_tx_data, chan_rx_rdy,
               outstanding, rsp_err, transactions_done
    );
endinterface

// File: rtl/cpu_multisim_client.sv
// CPU-side end of the multisim CPU<->NoC link: request/response buffering,
// outstanding-transaction limiting and end-of-traffic detection.
module cpu_multisim_client #(
    parameter int DATA_WIDTH      = 64,
    parameter int TX_DEPTH        = 4,
    parameter int RX_DEPTH        = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input logic                  clk,
    input logic                  rst,
    cpu_multisim_client_if.slave bus
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW:0]        tx_wptr, tx_rptr;
    logic                  tx_empty, tx_full, tx_push, tx_pop;

    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW:0]        rx_wptr, rx_rptr;
    logic                  rx_empty, rx_full, rx_push, rx_pop;

    logic [7:0] out_cnt;
    logic       err_q;
    logic [1:0] state;
    logic       done_q;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                      (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);
    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                      (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);

    // Readies are held low while reset is asserted so every output reads 0.
    assign bus.cpu_req_rdy  = !rst && !tx_full;
    assign bus.chan_rx_rdy  = !rst && !rx_full;
    assign bus.chan_tx_vld  = !tx_empty && (out_cnt < MAX_OUT);
    assign bus.chan_tx_data = bus.chan_tx_vld ? tx_mem[tx_rptr[TX_AW-1:0]] : '0;
    assign bus.cpu_rsp_vld  = !rx_empty;
    assign bus.cpu_rsp_data = rx_empty ? '0 : rx_mem[rx_rptr[RX_AW-1:0]];

    assign bus.outstanding       = out_cnt;
    assign bus.rsp_err           = err_q;
    assign bus.transactions_done = done_q;

    assign tx_push = bus.cpu_req_vld && bus.cpu_req_rdy;
    assign tx_pop  = bus.chan_tx_vld && bus.chan_tx_rdy;
    assign rx_push = bus.chan_rx_vld && bus.chan_rx_rdy;
    assign rx_pop  = bus.cpu_rsp_vld && bus.cpu_rsp_rdy;

    // Storage arrays need no reset: their contents are only visible through
    // the pointers, which are reset.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[TX_AW-1:0]] <= bus.cpu_req_data;
        if (rx_push) rx_mem[rx_wptr[RX_AW-1:0]] <= bus.chan_rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end

    // An unexpected response never drives the count below zero; it is only
    // flagged, and the payload is still buffered for the CPU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            if (tx_pop && !rx_push)
                out_cnt <= out_cnt + 8'd1;
            else if (rx_push && !tx_pop && out_cnt != 8'd0)
                out_cnt <= out_cnt - 8'd1;
            if (rx_push && out_cnt == 8'd0)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.cpu_last) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (tx_empty && out_cnt == 8'd0 && rx_empty) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_DONE;
                    done_q <= 1'b1;
                end
                default: begin
                    state  <= ST_RUN;
                    done_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_multisim_client.sv
// Self-checking bench for cpu_multisim_client: a queue-based model checked on
// every cycle plus directed scenarios with literal expectations.
module tb_cpu_multisim_client;
    localparam int DW   = 64;
    localparam int TXD  = 4;
    localparam int RXD  = 4;
    localparam int MAXO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cpu_multisim_client_if #(.DATA_WIDTH(DW)) bus ();

    cpu_multisim_client #(
        .DATA_WIDTH(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model state: what each FIFO holds, how many requests await answers,
    // whether the CPU has declared its last request, and completion.
    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_q[$];
    int m_out   = 0;
    bit m_err   = 1'b0;
    bit m_drain = 1'b0;
    bit m_done  = 1'b0;

    function automatic bit exp_req_rdy();
        return !rst && (tx_q.size() < TXD);
    endfunction
    function automatic bit exp_tx_vld();
        return (tx_q.size() > 0) && (m_out < MAXO);
    endfunction
    function automatic bit exp_rx_rdy();
        return !rst && (rx_q.size() < RXD);
    endfunction
    function automatic bit exp_rsp_vld();
        return rx_q.size() > 0;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            m_out   <= 0;
            m_err   <= 1'b0;
            m_drain <= 1'b0;
            m_done  <= 1'b0;
        end else begin
            bit tx_hs, push, rx_hs, pop;
            tx_hs = exp_tx_vld() && bus.chan_tx_rdy;
            push  = exp_req_rdy() && bus.cpu_req_vld;
            rx_hs = exp_rx_rdy() && bus.chan_rx_vld;
            pop   = exp_rsp_vld() && bus.cpu_rsp_rdy;
            if (!m_drain)
                m_drain <= bus.cpu_last;
            else if (tx_q.size() == 0 && m_out == 0 && rx_q.size() == 0)
                m_done <= 1'b1;
            if (tx_hs) void'(tx_q.pop_front());
            if (push)  tx_q.push_back(bus.cpu_req_data);
            if (pop)   void'(rx_q.pop_front());
            if (rx_hs) rx_q.push_back(bus.chan_rx_data);
            if (tx_hs && !rx_hs)
                m_out <= m_out + 1;
            else if (rx_hs && !tx_hs && m_out > 0)
                m_out <= m_out - 1;
            if (rx_hs && m_out == 0)
                m_err <= 1'b1;
        end
    end

    always @(negedge clk) begin
        checkOutput("cpu_req_rdy", bus.cpu_req_rdy, exp_req_rdy());
        checkOutput("chan_tx_vld", bus.chan_tx_vld, exp_tx_vld());
        if (exp_tx_vld()) checkOutput("chan_tx_data", bus.chan_tx_data, tx_q[0]);
        checkOutput("chan_rx_rdy", bus.chan_rx_rdy, exp_rx_rdy());
        checkOutput("cpu_rsp_vld", bus.cpu_rsp_vld, exp_rsp_vld());
        if (exp_rsp_vld()) checkOutput("cpu_rsp_data", bus.cpu_rsp_data, rx_q[0]);
        checkOutput("outstanding", bus.outstanding, 64'(m_out));
        checkOutput("rsp_err", bus.rsp_err, m_err);
        checkOutput("transactions_done", bus.transactions_done, m_done);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.cpu_req_vld  = 1'b0;
        bus.cpu_req_data = '0;
        bus.cpu_rsp_rdy  = 1'b0;
        bus.cpu_last     = 1'b0;
        bus.chan_tx_rdy  = 1'b0;
        bus.chan_rx_vld  = 1'b0;
        bus.chan_rx_data = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_word(input logic [DW-1:0] data);
        bit ok = 1'b0;
        bus.cpu_req_vld  = 1'b1;
        bus.cpu_req_data = data;
        for (int i = 0; i < 64; i++) begin
            if (bus.cpu_req_rdy) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.cpu_req_vld = 1'b0;
        checkOutput("push_accepted", 64'(ok), 64'd1);
    endtask

    task automatic offer_rsp(input logic [DW-1:0] data);
        bit ok = 1'b0;
        bus.chan_rx_vld  = 1'b1;
        bus.chan_rx_data = data;
        for (int i = 0; i < 64; i++) begin
            if (bus.chan_rx_rdy) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.chan_rx_vld = 1'b0;
        checkOutput("rsp_accepted", 64'(ok), 64'd1);
    endtask

    task automatic applyStimulus();
        logic [DW-1:0] w [10];
        logic [DW-1:0] r [5];
        for (int i = 0; i < 10; i++) w[i] = 64'h1000 + 64'(i);
        for (int i = 0; i < 5; i++)  r[i] = 64'hA0 + 64'(i);

        $display("[TB] single request");
        reset_dut();
        checkOutput("reset_req_rdy", bus.cpu_req_rdy, 64'd1);
        checkOutput("reset_outstanding", bus.outstanding, 64'd0);
        bus.chan_tx_rdy = 1'b1;
        bus.cpu_rsp_rdy = 1'b0;
        push_word(64'hDEAD_BEEF_0000_0001);
        checkOutput("single_tx_vld", bus.chan_tx_vld, 64'd1);
        checkOutput("single_tx_data", bus.chan_tx_data, 64'hDEAD_BEEF_0000_0001);
        tick();
        checkOutput("single_out_1", bus.outstanding, 64'd1);
        offer_rsp(64'h1234);
        checkOutput("single_rsp_vld", bus.cpu_rsp_vld, 64'd1);
        checkOutput("single_rsp_data", bus.cpu_rsp_data, 64'h1234);
        checkOutput("single_out_0", bus.outstanding, 64'd0);
        bus.cpu_rsp_rdy = 1'b1;
        tick();

        $display("[TB] tx full");
        reset_dut();
        for (int i = 0; i < 4; i++) push_word(w[i]);
        checkOutput("txfull_req_rdy", bus.cpu_req_rdy, 64'd0);
        bus.cpu_req_vld  = 1'b1;
        bus.cpu_req_data = w[4];
        tick();
        tick();
        checkOutput("txfull_still_full", bus.cpu_req_rdy, 64'd0);
        bus.cpu_req_vld = 1'b0;
        bus.chan_tx_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("txfull_order", bus.chan_tx_data, w[i]);
            tick();
        end
        checkOutput("txfull_out_4", bus.outstanding, 64'd4);

        $display("[TB] outstanding limit");
        reset_dut();
        bus.chan_tx_rdy = 1'b1;
        bus.cpu_rsp_rdy = 1'b1;
        for (int i = 0; i < 10; i++) push_word(w[i]);
        repeat (3) tick();
        checkOutput("limit_out_8", bus.outstanding, 64'd8);
        checkOutput("limit_tx_stalled", bus.chan_tx_vld, 64'd0);
        offer_rsp(r[0]);
        checkOutput("limit_out_7", bus.outstanding, 64'd7);
        checkOutput("limit_ninth_vld", bus.chan_tx_vld, 64'd1);
        checkOutput("limit_ninth_data", bus.chan_tx_data, w[8]);
        tick();
        checkOutput("limit_back_8", bus.outstanding, 64'd8);
        bus.chan_rx_vld  = 1'b1;
        bus.chan_rx_data = r[1];
        tick();
        checkOutput("limit_tenth_data", bus.chan_tx_data, w[9]);
        bus.chan_rx_data = r[2];
        tick();
        bus.chan_rx_vld = 1'b0;
        checkOutput("limit_simul_out", bus.outstanding, 64'd7);
        checkOutput("limit_tx_empty", bus.chan_tx_vld, 64'd0);
        repeat (3) tick();

        $display("[TB] rx backpressure");
        reset_dut();
        bus.chan_tx_rdy = 1'b1;
        for (int i = 0; i < 5; i++) push_word(w[i]);
        repeat (2) tick();
        for (int i = 0; i < 4; i++) offer_rsp(r[i]);
        checkOutput("rxbp_rx_rdy", bus.chan_rx_rdy, 64'd0);
        bus.chan_rx_vld  = 1'b1;
        bus.chan_rx_data = r[4];
        tick();
        tick();
        checkOutput("rxbp_out_1", bus.outstanding, 64'd1);
        bus.cpu_rsp_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("rxbp_vld", bus.cpu_rsp_vld, 64'd1);
            checkOutput("rxbp_order", bus.cpu_rsp_data, r[i]);
            tick();
            if (i == 1) bus.chan_rx_vld = 1'b0;
        end
        checkOutput("rxbp_drained", bus.cpu_rsp_vld, 64'd0);

        $display("[TB] done sequence");
        reset_dut();
        bus.chan_tx_rdy = 1'b1;
        for (int i = 0; i < 3; i++) push_word(w[i]);
        bus.cpu_last = 1'b1;
        repeat (3) tick();
        checkOutput("done_out_3", bus.outstanding, 64'd3);
        for (int i = 0; i < 3; i++) offer_rsp(r[i]);
        checkOutput("done_not_yet_rx", bus.transactions_done, 64'd0);
        bus.cpu_rsp_rdy = 1'b1;
        repeat (3) tick();
        checkOutput("done_not_before", bus.transactions_done, 64'd0);
        tick();
        checkOutput("done_rises", bus.transactions_done, 64'd1);
        push_word(w[5]);
        checkOutput("done_fwd_vld", bus.chan_tx_vld, 64'd1);
        tick();
        checkOutput("done_sticky", bus.transactions_done, 64'd1);

        $display("[TB] error and reset");
        reset_dut();
        offer_rsp(64'hE);
        checkOutput("err_set", bus.rsp_err, 64'd1);
        checkOutput("err_data", bus.cpu_rsp_data, 64'hE);
        checkOutput("err_out_0", bus.outstanding, 64'd0);
        push_word(w[0]);
        push_word(w[1]);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_req_rdy", bus.cpu_req_rdy, 64'd0);
        checkOutput("rst_rsp_vld", bus.cpu_rsp_vld, 64'd0);
        checkOutput("rst_tx_vld", bus.chan_tx_vld, 64'd0);
        checkOutput("rst_rx_rdy", bus.chan_rx_rdy, 64'd0);
        checkOutput("rst_tx_data", bus.chan_tx_data, 64'd0);
        checkOutput("rst_rsp_data", bus.cpu_rsp_data, 64'd0);
        checkOutput("rst_err", bus.rsp_err, 64'd0);
        checkOutput("rst_done", bus.transactions_done, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_req_rdy", bus.cpu_req_rdy, 64'd1);
        checkOutput("post_rst_rsp_vld", bus.cpu_rsp_vld, 64'd0);
        checkOutput("post_rst_tx_vld", bus.chan_tx_vld, 64'd0);
        checkOutput("post_rst_err", bus.rsp_err, 64'd0);
        tick();
    endtask

    initial begin
        applyStimulus();
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/cpu_multisim_client.md
Name: cpu_multisim_client

Overview:
- CPU-side end of the multisim CPU↔NoC link; counterpart of the per-CPU server that lives in the NoC simulation.
- Buffers CPU requests toward the cpu_to_noc channel and NoC responses from the noc_to_cpu channel.
- Enforces an outstanding-transaction limit.
- Raises transactions_done once the CPU has finished issuing and every request has been answered and drained.

Parameters:
- DATA_WIDTH, 64, payload width of both directions.
- TX_DEPTH, 4, request FIFO entries (power of 2, ≥2).
- RX_DEPTH, 4, response FIFO entries (power of 2, ≥2).
- MAX_OUTSTANDING, 8, max requests sent to the channel but not yet answered (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cpu_req_vld  in  1  CPU request valid
- cpu_req_rdy  out  1  request accepted when vld&rdy
- cpu_req_data  in  DATA_WIDTH  request payload
- cpu_rsp_vld  out  1  response valid to CPU
- cpu_rsp_rdy  in  1  CPU accepts response
- cpu_rsp_data  out  DATA_WIDTH  response payload
- cpu_last  in  1  level; CPU will issue no further requests
- chan_tx_vld  out  1  toward the cpu_to_noc client push channel
- chan_tx_rdy  in  1  channel accepts
- chan_tx_data  out  DATA_WIDTH  request payload to channel
- chan_rx_vld  in  1  from the noc_to_cpu client pull channel
- chan_rx_rdy  out  1  block accepts response
- chan_rx_data  in  DATA_WIDTH  response payload from channel
- outstanding  out  8  current outstanding count
- rsp_err  out  1  sticky: response arrived with outstanding==0
- transactions_done  out  1  all traffic complete

Behaviour:
- Reset (async assert, sync release): both FIFOs empty; outstanding=0; FSM=RUN; rsp_err=0.
  - All outputs 0: cpu_req_rdy, cpu_rsp_vld, chan_tx_vld, chan_rx_rdy, transactions_done, data outputs.
  - Reset mid-transfer discards all buffered data; no partial state survives.
- Handshake transfer: a transfer occurs on the rising edge where vld&rdy=1.
- Valid stability: every vld output, once high, holds with stable data until accepted.
- Ready independence: rdy outputs never depend combinationally on the same-interface vld.
- Request FIFO (registered, TX_DEPTH):
  - cpu_req_rdy = !tx_full, including in DRAIN/DONE.
  - A push while full is not accepted, even with a simultaneous pop (no bypass).
  - Write→chan_tx_vld latency is 1 cycle.
  - chan_tx_vld = !tx_empty && outstanding < MAX_OUTSTANDING; chan_tx_data = FIFO head.
  - The stall gate is held once vld is high: the counter can only fall while vld is up.
- Response FIFO (registered, RX_DEPTH):
  - chan_rx_rdy = !rx_full; cpu_rsp_vld = !rx_empty; cpu_rsp_data = head.
  - Channel→CPU latency is 1 cycle.
- Pointers: log2(depth)+1 bits, wrap naturally; full = MSBs differ and LSBs equal.
- Outstanding counter:
  - +1 on a chan_tx handshake; −1 on a chan_rx handshake.
  - Both in the same cycle → unchanged.
  - A chan_rx handshake at outstanding==0 leaves the count at 0, sets rsp_err, and the data is still buffered.
  - rsp_err clears only on rst.
- FSM:
  - RUN → DRAIN when cpu_last=1.
  - DRAIN → DONE when tx_empty && outstanding==0 && rx_empty, all sampled in the same cycle.
  - DONE is terminal until rst.
  - transactions_done = (FSM==DONE), registered, so it rises 1 cycle after the condition holds.
  - A request pushed during DRAIN keeps the FSM in DRAIN until it completes.
  - A request pushed in DONE is still forwarded, but transactions_done stays 1 (CPU protocol violation, not detected).

Test Plan:
- Single request: push 0xDEAD_BEEF_0000_0001 while chan_tx_rdy=1 → chan_tx_vld at the next cycle with the same data; outstanding goes 0→1. Return 0x1234 on chan_rx → cpu_rsp_vld one cycle later with 0x1234; outstanding→0.
- TX full: hold chan_tx_rdy=0 and push 4 words → cpu_req_rdy=0 after the 4th; a 5th held with vld stays unaccepted. Release chan_tx_rdy → words exit in order, one per cycle.
- Outstanding limit: MAX_OUTSTANDING=8, rx never responds, push 10 requests → exactly 8 reach the channel and outstanding=8. Send 1 response → the 9th request issues; simultaneous tx/rx keeps the count at 8.
- RX backpressure: cpu_rsp_rdy=0 and 5 responses offered → chan_rx_rdy=0 after 4 are buffered. Responses are delivered in order once cpu_rsp_rdy=1.
- Done sequence: 3 requests and 3 responses, cpu_last=1 after the 3rd push → transactions_done=1 exactly one cycle after the last response is popped by the CPU, not before.
- Error/reset: inject a response with outstanding=0 → rsp_err=1 and data delivered. Assert rst mid-burst → all outputs 0 asynchronously; after release, FIFOs are empty and rsp_err=0.
